tile_enable_sequencer: RTL
==========================

# tile_enable_sequencer

Control-side block that turns the tile-enable mask written at bring-up into ordered, glitch-free per-tile power-on and power-off sequences. The mask arrives over JTAG or serial link before any Cheshire or Snitch binary is preloaded. The sequencer walks the tiles one at a time: clock enable, settle, reset release, isolation release, and the reverse on disable. Preload traffic reaches a tile's memories only after its status bit is set. The block sits between the SoC control register bus and the tile clock/reset/isolation nets.

## Interface
- `NumTiles`, default 16: number of sequenced tiles; legal range 1..32.
- `ClkSettleCycles`, default 8: cycles between clock enable and reset release; must be ≥1.
- `RstHoldCycles`, default 4: cycles between reset release and isolation release, and between isolation and reset assert on disable; must be ≥1.
- `clk_i  in  1`: the only clock.
- `rst_i  in  1`: synchronous, active-high reset.
- `req_valid_i  in  1`: register request valid.
- `req_ready_o  out  1`: tied to 1; every request is accepted.
- `req_write_i  in  1`: 1 = write, 0 = read.
- `req_addr_i  in  4`: byte offset.
- `req_wdata_i  in  32`: write data.
- `rsp_valid_o  out  1`: one cycle after each accepted request.
- `rsp_rdata_o  out  32`: read data; 0 for writes.
- `rsp_error_o  out  1`: unmapped offset.
- `tile_clk_en_o  out  NumTiles`: per-tile clock gate enable.
- `tile_rst_o  out  NumTiles`: per-tile reset, active high.
- `tile_iso_o  out  NumTiles`: per-tile isolation, active high.
- `busy_o  out  1`: a tile sequence is in flight.
- `irq_o  out  1`: only with the macro (see Configuration).

## Operation
- **Registers**
  - 0x0 TARGET (RW): desired enable mask.
  - 0x4 STATUS (RO): completed enable mask.
  - 0x8 BUSY (RO): bit0 = busy_o.
  - 0xC IRQ (RW1C): only with the macro.
- **Register access rules**
  - Write bits ≥ NumTiles are dropped.
  - Writes to RO or unmapped offsets: no effect; rsp_error_o=1 for unmapped offsets only.
- **FSM states:** IDLE, EN_CLK, EN_SETTLE, EN_ISO, DIS_ISO, DIS_RST.
- **IDLE**
  - Pick the lowest index i with TARGET[i]≠STATUS[i], latch i.
  - TARGET[i]=1 → EN_CLK; otherwise → DIS_ISO.
  - No mismatch → stay in IDLE.
- **Enable path**
  - EN_CLK: clk_en[i]=1, load counter with ClkSettleCycles-1.
  - EN_SETTLE: count down to 0, then rst[i]=0 and reload with RstHoldCycles-1.
  - EN_ISO: count down to 0, then iso[i]=0 and STATUS[i]=1 → IDLE.
- **Disable path**
  - DIS_ISO: iso[i]=1, load RstHoldCycles-1, count down to 0.
  - DIS_RST: rst[i]=1 → next cycle clk_en[i]=0, STATUS[i]=0 → IDLE.
- **TARGET written while busy:** accepted. The in-flight tile always completes its sequence, even if its own TARGET bit flipped. The next IDLE scan uses the new TARGET.
- **Counter:** width $clog2(max(ClkSettleCycles,RstHoldCycles)+1); no wrap-around is possible.

## Timing
- **Reset values**
  - tile_clk_en_o=0, tile_rst_o='1, tile_iso_o='1.
  - TARGET=0, STATUS=0, busy_o=0, rsp_valid_o=0, irq_o=0.
  - FSM = IDLE.
- **Reset mid-sequence:** all outputs return to their reset values on the next edge, with no ordering.
- **Outputs:** all registered.
- **Enable latency** (TARGET write accepted in cycle 0):
  - Cycle 1: IDLE scan.
  - Cycle 2: clk_en=1, busy_o=1.
  - Cycle 2+ClkSettleCycles: rst=0.
  - Cycle 2+ClkSettleCycles+RstHoldCycles: iso=0, STATUS bit set.
  - Next cycle: busy_o=0 if no work remains.
- **Disable latency:** iso=1 at cycle 2; rst=1 at 2+RstHoldCycles; clk_en=0 at 3+RstHoldCycles.
- **Multiple tiles:** processed back to back; each adds one IDLE cycle between sequences.
- **Simultaneous read of STATUS and its update:** the read returns the pre-update value.

## Configuration
- `PICOBELLO_TILE_SEQ_IRQ_EN` defined:
  - irq_o port and the IRQ register exist.
  - irq_o sets when the FSM returns to IDLE and TARGET==STATUS; it stays set until 1 is written to bit0 at 0xC.
  - A set and a clear in the same cycle: set wins.
- Undefined: no irq_o port; 0xC is unmapped (rsp_error_o=1).

## Structure
- `tile_seq_pkg` holds:
  - register offsets
  - the FSM state enum
  - the max-tile constant (32)
- One sub-module, `tile_seq_regs`, holds:
  - request decode, TARGET/IRQ storage, response register.
  - It exports TARGET and takes STATUS/busy in.
- The FSM, counter and output registers live in the top.

## Test plan
- Reset, then read 0x0/0x4/0x8 → all 0; tile_rst_o=0xFFFF, tile_iso_o=0xFFFF, tile_clk_en_o=0.
- Write TARGET=0x0001 (defaults) → clk_en[0] at cycle 2, rst[0]=0 at cycle 10, iso[0]=0 and STATUS=0x0001 at cycle 14, busy_o=0 at cycle 15.
- Write TARGET=0x8005 → tiles 0, 2, 15 enabled in that order, sequences 13 cycles apart; other tiles untouched.
- From STATUS=0x0005, write TARGET=0x0004 → tile 0: iso=1 at cycle 2, rst=1 at cycle 6, clk_en=0 at cycle 7; tile 2 unchanged.
- Write TARGET=0x0003, then TARGET=0x0002 during tile 0's settle → tile 0 completes enable, then is disabled, then tile 1 is enabled; final STATUS=0x0002.
- Assert rst_i mid-EN_SETTLE → all outputs return to reset values next cycle. With the macro, irq_o rises after a full enable of 0x0001 and clears on writing 0x1 to 0xC; a read of 0x10 gives rsp_error_o=1.

Source files
------------

// File: rtl/tile_seq_pkg.sv
// Shared definitions for the tile enable sequencer: register offsets,
// FSM state encoding and the upper bound on the number of tiles.
package tile_seq_pkg;

  localparam int unsigned MaxTiles = 32;

  localparam logic [3:0] OffTarget = 4'h0;
  localparam logic [3:0] OffStatus = 4'h4;
  localparam logic [3:0] OffBusy   = 4'h8;
  localparam logic [3:0] OffIrq    = 4'hC;

  typedef enum logic [2:0] {
    IDLE,
    EN_CLK,
    EN_SETTLE,
    EN_ISO,
    DIS_ISO,
    DIS_RST
  } seq_state_e;

endpackage

// File: rtl/tile_seq_regs.sv
// Register front end: request decode, TARGET storage and the response register.
// With PICOBELLO_TILE_SEQ_IRQ_EN defined it also holds the sticky IRQ flag at 0xC.
module tile_seq_regs
  import tile_seq_pkg::*;
#(
  parameter int unsigned NumTiles = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [3:0]          req_addr_i,
  input  logic [31:0]         req_wdata_i,
  input  logic [NumTiles-1:0] status_i,
  input  logic                busy_i,
  output logic [NumTiles-1:0] target_o,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_error_o
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
  ,
  input  logic                irq_set_i,
  output logic                irq_o
`endif
);

  logic [NumTiles-1:0] target_q;
  logic [MaxTiles-1:0] target_pad;
  logic [MaxTiles-1:0] status_pad;

  always_comb begin
    target_pad = '0;
    status_pad = '0;
    target_pad[NumTiles-1:0] = target_q;
    status_pad[NumTiles-1:0] = status_i;
  end

`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
  logic irq_q;
  logic irq_clr;

  assign irq_clr = req_valid_i & req_write_i & (req_addr_i == OffIrq) & req_wdata_i[0];
  assign irq_o   = irq_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= req_valid_i;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      if (req_valid_i) begin
        case (req_addr_i)
          OffTarget: begin
            // Bits at or above NumTiles simply fall off the slice.
            if (req_write_i) target_q <= req_wdata_i[NumTiles-1:0];
            else             rsp_rdata_o <= target_pad;
          end
          OffStatus: if (!req_write_i) rsp_rdata_o <= status_pad;
          OffBusy:   if (!req_write_i) rsp_rdata_o <= {31'b0, busy_i};
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
          OffIrq:    if (!req_write_i) rsp_rdata_o <= {31'b0, irq_q};
`endif
          default:   rsp_error_o <= 1'b1;
        endcase
      end
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
      irq_q <= irq_set_i | (irq_q & ~irq_clr);
`endif
    end
  end

  assign target_o = target_q;

endmodule

// File: rtl/tile_enable_sequencer.sv
// Walks tiles one at a time through clock enable, settle, reset release and
// isolation release (and the reverse). Optional irq_o via PICOBELLO_TILE_SEQ_IRQ_EN.
//
// state     | meaning
// IDLE      | scan for lowest tile whose TARGET and STATUS differ
// EN_CLK    | clock enabled, first settle cycle
// EN_SETTLE | waiting for clock to settle before reset release
// EN_ISO    | reset released, holding before isolation release
// DIS_ISO   | isolation asserted, holding before reset assert
// DIS_RST   | reset asserted, clock gated next
module tile_enable_sequencer
  import tile_seq_pkg::*;
#(
  parameter int unsigned NumTiles        = 16,
  parameter int unsigned ClkSettleCycles = 8,
  parameter int unsigned RstHoldCycles   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [3:0]          req_addr_i,
  input  logic [31:0]         req_wdata_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_error_o,
  output logic [NumTiles-1:0] tile_clk_en_o,
  output logic [NumTiles-1:0] tile_rst_o,
  output logic [NumTiles-1:0] tile_iso_o,
  output logic                busy_o
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
  ,
  output logic                irq_o
`endif
);

  localparam int unsigned CntMax = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles
                                                                     : RstHoldCycles;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam int unsigned IdxW = (NumTiles > 1) ? $clog2(NumTiles) : 1;

  localparam logic [CntW-1:0] SettleLoad = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] HoldLoad   = CntW'(RstHoldCycles - 1);

  seq_state_e          state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [NumTiles-1:0] status_q;
  logic [NumTiles-1:0] target;
  logic [NumTiles-1:0] diff;
  logic [IdxW-1:0]     pick;
  logic                found;

  assign req_ready_o = 1'b1;

`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
  logic done_q;
  logic irq_set;
  assign irq_set = done_q && (target == status_q);
`endif

  tile_seq_regs #(
    .NumTiles (NumTiles)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .status_i    (status_q),
    .busy_i      (busy_o),
    .target_o    (target),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o)
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
    ,
    .irq_set_i   (irq_set),
    .irq_o       (irq_o)
`endif
  );

  // Descending loop so the lowest mismatching index wins.
  always_comb begin
    diff  = target ^ status_q;
    found = 1'b0;
    pick  = '0;
    for (int i = NumTiles - 1; i >= 0; i--) begin
      if (diff[i]) begin
        found = 1'b1;
        pick  = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      status_q      <= '0;
      tile_clk_en_o <= '0;
      tile_rst_o    <= '1;
      tile_iso_o    <= '1;
      busy_o        <= 1'b0;
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
      done_q        <= 1'b0;
`endif
    end else begin
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          busy_o <= found;
          if (found) begin
            idx_q <= pick;
            if (target[pick]) begin
              tile_clk_en_o[pick] <= 1'b1;
              cnt_q               <= SettleLoad;
              state_q             <= EN_CLK;
            end else begin
              tile_iso_o[pick] <= 1'b1;
              cnt_q            <= HoldLoad;
              state_q          <= DIS_ISO;
            end
          end
        end
        EN_CLK, EN_SETTLE: begin
          if (cnt_q == '0) begin
            tile_rst_o[idx_q] <= 1'b0;
            cnt_q             <= HoldLoad;
            state_q           <= EN_ISO;
          end else begin
            cnt_q   <= cnt_q - 1'b1;
            state_q <= EN_SETTLE;
          end
        end
        EN_ISO: begin
          if (cnt_q == '0) begin
            tile_iso_o[idx_q] <= 1'b0;
            status_q[idx_q]   <= 1'b1;
            state_q           <= IDLE;
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
            done_q            <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIS_ISO: begin
          if (cnt_q == '0) begin
            tile_rst_o[idx_q] <= 1'b1;
            state_q           <= DIS_RST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DIS_RST: begin
          tile_clk_en_o[idx_q] <= 1'b0;
          status_q[idx_q]      <= 1'b0;
          state_q              <= IDLE;
`ifdef PICOBELLO_TILE_SEQ_IRQ_EN
          done_q               <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
